// File: rtl/map_sprite_multi.sv
// Tile-map renderer with per-frame-latched ball overlays and a disc mask per tile.
// Five-cycle pixel pipeline: map ROM (2), palette ROM (2), output register (1).
module map_sprite_multi #(
    parameter int          MAP_W     = 160,
    parameter int          MAP_H     = 90,
    parameter int          TILE_LOG2 = 3,
    parameter int          N_MAPS    = 2,
    parameter int          N_BALLS   = 2,
    parameter logic [23:0] EDGE_RGB  = 24'h7CFC00,
    parameter logic [24*N_BALLS-1:0] BALL_RGB = {N_BALLS{24'hFFFFFF}}
) (
    input  logic                                              pixel_clk_in,
    input  logic                                              rst_in,
    input  logic [10:0]                                       hcount_in,
    input  logic [9:0]                                        vcount_in,
    input  logic                                              new_frame_in,
    input  logic [((N_MAPS > 1) ? $clog2(N_MAPS) : 1)-1:0]    map_sel_in,
    input  logic [8*N_BALLS-1:0]                              ball_x_in,
    input  logic [7*N_BALLS-1:0]                              ball_y_in,
    input  logic [N_BALLS-1:0]                                ball_en_in,
    output logic [7:0]                                        red_out,
    output logic [7:0]                                        green_out,
    output logic [7:0]                                        blue_out
);

    localparam int T      = 1 << TILE_LOG2;
    localparam int MAP_SZ = MAP_W * MAP_H;
    localparam int AW     = $clog2(N_MAPS * MAP_SZ);
    localparam int SW     = (N_MAPS > 1) ? $clog2(N_MAPS) : 1;
    localparam int IW     = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;

    // Map tile index: XOR-fold of the ROM address into one nibble.
    function automatic logic [3:0] map_rom(input logic [AW-1:0] a);
        logic [3:0] v;
        v = 4'h0;
        for (int b = 0; b < AW; b++) begin
            v[b % 4] = v[b % 4] ^ a[b];
        end
        return v;
    endfunction

    function automatic logic [23:0] pal_rom(input logic [3:0] idx);
        logic [23:0] c;
        case (idx)
            4'h0:    c = 24'h000000;
            4'h1:    c = 24'hFF0000;
            4'h2:    c = 24'h00FF00;
            4'h3:    c = 24'h0000FF;
            4'h4:    c = 24'hFFFF00;
            4'h5:    c = 24'h00FFFF;
            4'h6:    c = 24'hFF00FF;
            4'h7:    c = 24'h808080;
            4'h8:    c = 24'h102030;
            4'h9:    c = 24'h400000;
            4'hA:    c = 24'h004000;
            4'hB:    c = 24'h000040;
            4'hC:    c = 24'hC0C0C0;
            4'hD:    c = 24'h00A0A0;
            4'hE:    c = 24'hA000A0;
            default: c = 24'h123456;
        endcase
        return c;
    endfunction

    function automatic logic sel_ok(input logic [SW-1:0] s);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < N_MAPS; k++) begin
            if (s == SW'(k)) ok = 1'b1;
        end
        return ok;
    endfunction

    // Shadow registers, updated only on the frame strobe.
    logic [8*N_BALLS-1:0] r_ball_x;
    logic [7*N_BALLS-1:0] r_ball_y;
    logic [N_BALLS-1:0]   r_ball_en;
    logic [SW-1:0]        r_map_sel;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_ball_x  <= '0;
            r_ball_y  <= '0;
            r_ball_en <= '0;
            r_map_sel <= '0;
        end else if (new_frame_in) begin
            r_ball_x  <= ball_x_in;
            r_ball_y  <= ball_y_in;
            r_ball_en <= ball_en_in;
            if (sel_ok(map_sel_in)) begin
                r_map_sel <= map_sel_in;
            end
        end
    end

    // Stage 0: tile coordinates, address, range, disc mask, ball hit.
    logic [10:0]          w_tx;
    logic [9:0]           w_ty;
    logic [TILE_LOG2-1:0] w_lx;
    logic [TILE_LOG2-1:0] w_ly;
    logic                 w_in_range;
    logic [AW-1:0]        w_addr;
    int                   w_dx;
    int                   w_dy;
    logic                 w_mask;
    logic                 w_hit;
    logic [IW-1:0]        w_idx;

    assign w_tx       = hcount_in >> TILE_LOG2;
    assign w_ty       = vcount_in >> TILE_LOG2;
    assign w_lx       = hcount_in[TILE_LOG2-1:0];
    assign w_ly       = vcount_in[TILE_LOG2-1:0];
    assign w_in_range = (32'(hcount_in) < 32'(MAP_W * T)) && (32'(vcount_in) < 32'(MAP_H * T));
    assign w_addr     = AW'(32'(r_map_sel) * 32'(MAP_SZ) + 32'(w_ty) * 32'(MAP_W) + 32'(w_tx));

    always_comb begin
        w_dx   = 2 * int'(w_lx) - (T - 1);
        w_dy   = 2 * int'(w_ly) - (T - 1);
        w_mask = (w_dx * w_dx + w_dy * w_dy) <= T * T;
    end

    // Scan from the top index down so the lowest enabled hit wins.
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = N_BALLS - 1; i >= 0; i--) begin
            if (r_ball_en[i] && (32'(w_tx) == 32'(r_ball_x[8*i +: 8]))
                             && (32'(w_ty) == 32'(r_ball_y[7*i +: 7]))) begin
                w_hit = 1'b1;
                w_idx = IW'(i);
            end
        end
    end

    // Side-band flags travel alongside the ROM reads; index 3 aligns with palette data.
    logic [3:0]          r_vld;
    logic [3:0]          r_rng;
    logic [3:0]          r_hit;
    logic [3:0]          r_mask;
    logic [3:0][IW-1:0]  r_idx;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_vld  <= '0;
            r_rng  <= '0;
            r_hit  <= '0;
            r_mask <= '0;
            r_idx  <= '0;
        end else begin
            r_vld  <= {r_vld[2:0], 1'b1};
            r_rng  <= {r_rng[2:0], w_in_range};
            r_hit  <= {r_hit[2:0], w_hit};
            r_mask <= {r_mask[2:0], w_mask};
            r_idx  <= {r_idx[2:0], w_idx};
        end
    end

    logic [AW-1:0] r_addr;
    logic [3:0]    r_map_data;
    logic [3:0]    r_pal_idx;
    logic [23:0]   r_pal_rgb;

    always_ff @(posedge pixel_clk_in) begin
        r_addr     <= w_addr;
        r_map_data <= map_rom(r_addr);
        r_pal_idx  <= r_map_data;
        r_pal_rgb  <= pal_rom(r_pal_idx);
    end

    logic [23:0] w_rgb;

    always_comb begin
        w_rgb = 24'h000000;
        if (r_vld[3] && r_rng[3]) begin
            if (r_hit[3]) begin
                w_rgb = r_mask[3] ? BALL_RGB[24*32'(r_idx[3]) +: 24] : r_pal_rgb;
            end else begin
                w_rgb = r_pal_rgb;
                for (int c = 0; c < 3; c++) begin
                    if (!r_mask[3] && (w_rgb[8*c +: 8] == 8'h00)) begin
                        w_rgb[8*c +: 8] = EDGE_RGB[8*c +: 8];
                    end
                end
            end
        end
    end

    logic [23:0] r_rgb;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rgb <= 24'h000000;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign red_out   = r_rgb[23:16];
    assign green_out = r_rgb[15:8];
    assign blue_out  = r_rgb[7:0];

endmodule

// File: tb/tb_map_sprite_multi.sv
// Bench for map_sprite_multi: per-cycle comparison against a pixel-rule model plus
// literal pins for the model itself.
module tb_map_sprite_multi;

    localparam int MAP_W = 160;
    localparam int MAP_H = 90;
    localparam int T     = 8;
    localparam int NM    = 3;
    localparam int NB    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hc = '0;
    logic [9:0]  vc = '0;
    logic        nf = 1'b0;
    logic [1:0]  msel = '0;
    logic [15:0] bx = '0;
    logic [13:0] by = '0;
    logic [1:0]  ben = '0;
    logic [7:0]  red, green, blue;

    always #5 clk = ~clk;

    map_sprite_multi #(
        .MAP_W    (MAP_W),
        .MAP_H    (MAP_H),
        .TILE_LOG2(3),
        .N_MAPS   (NM),
        .N_BALLS  (NB),
        .EDGE_RGB (24'h7CFC00),
        .BALL_RGB ({24'hFF0000, 24'hFFFFFF})
    ) dut (
        .pixel_clk_in(clk),
        .rst_in      (rst),
        .hcount_in   (hc),
        .vcount_in   (vc),
        .new_frame_in(nf),
        .map_sel_in  (msel),
        .ball_x_in   (bx),
        .ball_y_in   (by),
        .ball_en_in  (ben),
        .red_out     (red),
        .green_out   (green),
        .blue_out    (blue)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [23:0] pal [0:15] = '{24'h000000, 24'hFF0000, 24'h00FF00, 24'h0000FF,
                                24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h808080,
                                24'h102030, 24'h400000, 24'h004000, 24'h000040,
                                24'hC0C0C0, 24'h00A0A0, 24'hA000A0, 24'h123456};
    logic [47:0] ball_rgb = {24'hFF0000, 24'hFFFFFF};
    logic [23:0] edge_rgb = 24'h7CFC00;

    function automatic logic [23:0] model_px(int h, int v, int sel, logic [15:0] sx,
                                             logic [13:0] sy, logic [1:0] se);
        int tx, ty, lx, ly, dx, dy, a, win;
        bit msk;
        logic [23:0] c;
        if (h >= MAP_W * T || v >= MAP_H * T) return 24'h000000;
        tx = h / T;
        ty = v / T;
        lx = h % T;
        ly = v % T;
        dx = 2 * lx - (T - 1);
        dy = 2 * ly - (T - 1);
        msk = (dx * dx + dy * dy) <= T * T;
        a = sel * MAP_W * MAP_H + ty * MAP_W + tx;
        c = pal[(a ^ (a >> 4) ^ (a >> 8) ^ (a >> 12)) & 15];
        win = -1;
        for (int i = NB - 1; i >= 0; i--)
            if (se[i] && sx[8*i +: 8] == tx && sy[7*i +: 7] == ty) win = i;
        if (win >= 0) return msk ? ball_rgb[24*win +: 24] : c;
        for (int k = 0; k < 3; k++)
            if (!msk && c[8*k +: 8] == 8'h00) c[8*k +: 8] = edge_rgb[8*k +: 8];
        return c;
    endfunction

    // Model state: frame-latched ball/map values and the last five sampled pixels.
    int          m_sel = 0;
    logic [15:0] m_x = '0;
    logic [13:0] m_y = '0;
    logic [1:0]  m_en = '0;
    logic [23:0] hist [0:4];
    bit          hv [0:4];

    initial begin
        for (int k = 0; k < 5; k++) begin hist[k] = '0; hv[k] = 1'b0; end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int k = 0; k < 5; k++) hv[k] = 1'b0;
                m_sel = 0; m_x = '0; m_y = '0; m_en = '0;
            end else begin
                for (int k = 4; k > 0; k--) begin hist[k] = hist[k-1]; hv[k] = hv[k-1]; end
                hist[0] = model_px(int'(hc), int'(vc), m_sel, m_x, m_y, m_en);
                hv[0] = 1'b1;
                if (nf) begin
                    m_x = bx; m_y = by; m_en = ben;
                    if (msel < NM) m_sel = int'(msel);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h at %0t", nm, got, exp, $time);
        end
    endtask

    initial begin
        logic [23:0] exp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp = rst ? 24'h000000 : (hv[4] ? hist[4] : 24'h000000);
                check("pipe", {red, green, blue}, exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input string nm, input int h, input int v, input logic [23:0] exp);
        hc = 11'(h);
        vc = 10'(v);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check(nm, {red, green, blue}, exp);
        step();
    endtask

    task automatic pulse();
        nf = 1'b1;
        step();
        nf = 1'b0;
    endtask

    initial begin
        int rnd;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("in_reset", {red, green, blue}, 24'h000000);
        step();
        rst = 1'b0;

        pin("t00_inside", 3, 3, 24'h000000);
        pin("t00_c00", 0, 0, 24'h7CFC00);
        pin("t00_c10", 1, 0, 24'h7CFC00);
        pin("t00_c20", 2, 0, 24'h000000);
        pin("t00_c77", 7, 7, 24'h7CFC00);

        bx = {8'd0, 8'd3}; by = {7'd0, 7'd2}; ben = 2'b01;
        pulse();
        pin("b0_disc", 27, 20, 24'hFFFFFF);
        pin("b0_corner", 24, 16, 24'hFF00FF);
        for (int h = 24; h < 32; h++) begin hc = 11'(h); vc = 10'd20; step(); end

        bx = {8'd5, 8'd5}; by = {7'd5, 7'd5}; ben = 2'b11;
        pulse();
        pin("tie_disc", 44, 44, 24'hFFFFFF);
        pin("tie_corner", 40, 40, 24'hFFFF00);

        bx = {8'd5, 8'd9}; msel = 2'd1;
        pin("hold_ball", 44, 44, 24'hFFFFFF);
        pin("hold_map", 0, 0, 24'h7CFC00);
        pulse();
        pin("new_map", 0, 0, 24'h123456);
        pin("ball1_shown", 44, 44, 24'hFF0000);
        msel = 2'd3;
        pulse();
        pin("sel_ignored", 0, 0, 24'h123456);

        pin("oor_h", 1280, 0, 24'h000000);
        pin("oor_v", 0, 720, 24'h000000);

        msel = 2'd0;
        pulse();
        hc = 11'd44; vc = 10'd44;
        repeat (6) step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {red, green, blue}, 24'h000000);
        step();
        step();
        rst = 1'b0;
        pin("ball_off", 44, 44, 24'hFFFF00);

        for (int n = 0; n < 4000; n++) begin
            rnd = int'($urandom_range(0, 99));
            if (rnd < 60) begin
                hc = 11'($urandom_range(0, 127));
                vc = 10'($urandom_range(0, 127));
            end else begin
                hc = 11'($urandom_range(0, 1400));
                vc = 10'($urandom_range(0, 800));
            end
            nf   = ($urandom_range(0, 29) == 0);
            bx   = {8'($urandom_range(0, 15)), 8'($urandom_range(0, 15))};
            by   = {7'($urandom_range(0, 15)), 7'($urandom_range(0, 15))};
            ben  = 2'($urandom);
            msel = 2'($urandom);
            rst  = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        nf  = 1'b0;
        repeat (8) step();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
